// File: rtl/spike_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : spike_mac_seq
// Brief    : Sequential spike-weighted accumulator, one synapse per clock, with
//            valid/ready handshakes and chaining across packets.
//            Optional macro SPIKE_MAC_SATURATE_EN: clamp on signed overflow
//            instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module spike_mac_seq #(
    parameter int NUM_INPUTS   = 4,
    parameter int WEIGHT_WIDTH = 32,
    parameter int ACC_WIDTH    = 32
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic                               start_valid,
    output logic                               start_ready,
    input  logic                               clear_acc,
    input  logic [NUM_INPUTS-1:0]              spike_in,
    input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0] weights_in,
    output logic                               result_valid,
    input  logic                               result_ready,
    output logic [ACC_WIDTH-1:0]               result,
    output logic                               overflow
);

    localparam int c_IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [c_IDX_W-1:0]   c_LAST_IDX = c_IDX_W'(NUM_INPUTS - 1);
    localparam logic [ACC_WIDTH-1:0] c_ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] c_ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                         r_state;
    logic [c_IDX_W-1:0]             r_idx;
    logic [NUM_INPUTS-1:0]          r_spikes;
    logic signed [WEIGHT_WIDTH-1:0] r_weights [NUM_INPUTS];
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic [ACC_WIDTH-1:0]           r_result;
    logic                           r_result_valid;
    logic                           r_start_ready;
    logic                           r_overflow;

    logic signed [WEIGHT_WIDTH-1:0] w_weight;
    logic signed [ACC_WIDTH-1:0]    w_add;
    logic signed [ACC_WIDTH-1:0]    w_sum;
    logic signed [ACC_WIDTH-1:0]    w_next_acc;
    logic                           w_ovf;

    // Unspiked synapses contribute zero, so they can never raise overflow.
    always_comb begin
        w_weight   = r_weights[r_idx];
        w_add      = r_spikes[r_idx] ? ACC_WIDTH'(w_weight) : '0;
        w_sum      = r_acc + w_add;
        w_ovf      = (r_acc[ACC_WIDTH-1] == w_add[ACC_WIDTH-1]) &&
                     (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
        w_next_acc = w_sum;
`ifdef SPIKE_MAC_SATURATE_EN
        if (w_ovf) begin
            w_next_acc = w_add[ACC_WIDTH-1] ? c_ACC_MIN : c_ACC_MAX;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_spikes       <= '0;
            r_acc          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_start_ready  <= 1'b1;
            r_overflow     <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                r_weights[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid && r_start_ready) begin
                        r_spikes <= spike_in;
                        for (int i = 0; i < NUM_INPUTS; i++) begin
                            r_weights[i] <= weights_in[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                        end
                        r_idx         <= '0;
                        r_start_ready <= 1'b0;
                        r_state       <= ACCUM;
                        if (clear_acc) begin
                            r_acc      <= '0;
                            r_overflow <= 1'b0;
                        end
                    end
                end
                ACCUM: begin
                    r_acc      <= w_next_acc;
                    r_overflow <= r_overflow | w_ovf;
                    if (r_idx == c_LAST_IDX) begin
                        // Capture the final sum so the result holds under backpressure.
                        r_result       <= w_next_acc;
                        r_result_valid <= 1'b1;
                        r_idx          <= '0;
                        r_state        <= DONE;
                    end else begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_start_ready  <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_result_valid <= 1'b0;
                    r_start_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign start_ready  = r_start_ready;
    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire
